// File: rtl/syzygy_dac_multi_controller_if.sv
// SPI master command/response bundle between the DAC sequencer and the existing SPI master.
interface syzygy_dac_multi_controller_if;
  logic [5:0] spi_reg;
  logic [7:0] spi_data_in;
  logic       spi_rw;
  logic       spi_send;
  logic       spi_done;
  logic [7:0] spi_data_out;

  modport master (
    output spi_reg, spi_data_in, spi_rw, spi_send,
    input  spi_done, spi_data_out
  );

  modport slave (
    input  spi_reg, spi_data_in, spi_rw, spi_send,
    output spi_done, spi_data_out
  );
endinterface

// File: rtl/syzygy_dac_multi_controller.sv
// SYZYGY DAC pod configuration sequencer: programs RCML/RSET per channel over SPI,
// optionally verifies by readback, then rewrites RSET whenever a channel's FSADJ changes.
module syzygy_dac_multi_controller #(
  parameter int                  NUM_CH     = 2,
  parameter logic [6*NUM_CH-1:0] RCML_ADDRS = {6'h08, 6'h05},
  parameter logic [6*NUM_CH-1:0] RSET_ADDRS = {6'h07, 6'h04},
  parameter logic [7:0]          RCML_VALUE = 8'h80,
  parameter bit                  VERIFY     = 1'b1,
  parameter int                  MAX_RETRY  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [6*NUM_CH-1:0]           dac_fsadj,
  input  logic                          reinit,
  syzygy_dac_multi_controller_if.master spi,
  output logic                          dac_ready,
  output logic                          cfg_error,
  output logic [1:0]                    err_ch
);

  // state        | meaning
  // S_BEGIN      | clear sequence context, start at RCML ch0
  // S_RCML_START | issue RCML write for ch
  // S_RCML_WAIT  | wait for SPI master to finish RCML write
  // S_RSET_START | issue RSET write for ch, capture fsadj into hold
  // S_RSET_WAIT  | wait for SPI master to finish RSET write
  // S_VFY_START  | issue readback of the register just written
  // S_VFY_WAIT   | wait for readback, capture compare result
  // S_CHECK      | advance, retry, or fail on readback result
  // S_READY      | configured; launch RSET rewrite of lowest dirty channel
  // S_ERROR      | verify exhausted retries; wait for reinit/reset
  typedef enum logic [3:0] {
    S_BEGIN, S_RCML_START, S_RCML_WAIT, S_RSET_START, S_RSET_WAIT,
    S_VFY_START, S_VFY_WAIT, S_CHECK, S_READY, S_ERROR
  } state_t;

  localparam logic [1:0] LAST_CH   = 2'(NUM_CH - 1);
  localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);

  state_t              state, state_nxt;
  logic [1:0]          ch, ch_nxt, err_ch_nxt, dirty_ch;
  logic                rset_ph, rset_ph_nxt;
  logic                upd, upd_nxt;
  logic                pend, pend_nxt;
  logic [2:0]          retry, retry_nxt;
  logic                vfy_ok, adv, is_wait, xfer_done;
  logic [6*NUM_CH-1:0] hold;
  logic [NUM_CH-1:0]   dirty;
  logic [5:0]          reg_q, sel_code, sel_rcml, sel_rset;
  logic [7:0]          data_q;
  logic                rw_q;

  assign sel_code = dac_fsadj[6*ch_nxt +: 6];
  assign sel_rcml = RCML_ADDRS[6*ch_nxt +: 6];
  assign sel_rset = RSET_ADDRS[6*ch_nxt +: 6];

  assign is_wait   = (state == S_RCML_WAIT) || (state == S_RSET_WAIT) || (state == S_VFY_WAIT);
  // spi_done is stale while our own send pulse is up
  assign xfer_done = spi.spi_done && !spi.spi_send;

  always_comb begin
    dirty_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (dirty[i]) dirty_ch = 2'(i);
  end

  always_comb begin
    state_nxt   = state;
    ch_nxt      = ch;
    rset_ph_nxt = rset_ph;
    upd_nxt     = upd;
    retry_nxt   = retry;
    pend_nxt    = pend;
    err_ch_nxt  = err_ch;
    adv         = 1'b0;
    if (is_wait) pend_nxt = pend | reinit;
    case (state)
      S_BEGIN: begin
        ch_nxt      = '0;
        rset_ph_nxt = 1'b0;
        upd_nxt     = 1'b0;
        retry_nxt   = '0;
        pend_nxt    = 1'b0;
        err_ch_nxt  = '0;
        state_nxt   = S_RCML_START;
      end
      S_RCML_START: state_nxt = S_RCML_WAIT;
      S_RSET_START: state_nxt = S_RSET_WAIT;
      S_VFY_START:  state_nxt = S_VFY_WAIT;
      S_RCML_WAIT, S_RSET_WAIT: begin
        if (xfer_done) begin
          if (pend || reinit)     state_nxt = S_BEGIN;
          else if (VERIFY != 1'b0) state_nxt = S_VFY_START;
          else                    adv = 1'b1;
        end
      end
      S_VFY_WAIT: begin
        if (xfer_done) state_nxt = (pend || reinit) ? S_BEGIN : S_CHECK;
      end
      S_CHECK: begin
        if (vfy_ok) begin
          retry_nxt = '0;
          adv       = 1'b1;
        end else if (retry < RETRY_LIM) begin
          retry_nxt = retry + 3'd1;
          state_nxt = rset_ph ? S_RSET_START : S_RCML_START;
        end else begin
          err_ch_nxt = ch;
          state_nxt  = S_ERROR;
        end
      end
      S_READY: begin
        if (dirty != '0) begin
          upd_nxt     = 1'b1;
          rset_ph_nxt = 1'b1;
          ch_nxt      = dirty_ch;
          state_nxt   = S_RSET_START;
        end
      end
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_BEGIN;
    endcase

    if (adv) begin
      if (!rset_ph) begin
        if (ch == LAST_CH) begin
          rset_ph_nxt = 1'b1;
          ch_nxt      = '0;
          state_nxt   = S_RSET_START;
        end else begin
          ch_nxt    = ch + 2'd1;
          state_nxt = S_RCML_START;
        end
      end else if (upd || ch == LAST_CH) begin
        upd_nxt   = 1'b0;
        state_nxt = S_READY;
      end else begin
        ch_nxt    = ch + 2'd1;
        state_nxt = S_RSET_START;
      end
    end

    // outside a transfer reinit wins immediately; inside one it waits via pend
    if (reinit && !is_wait) begin
      state_nxt  = S_BEGIN;
      retry_nxt  = '0;
      err_ch_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_BEGIN;
      ch      <= '0;
      rset_ph <= 1'b0;
      upd     <= 1'b0;
      pend    <= 1'b0;
      retry   <= '0;
      err_ch  <= '0;
      vfy_ok  <= 1'b0;
      hold    <= '0;
      dirty   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      rset_ph <= rset_ph_nxt;
      upd     <= upd_nxt;
      pend    <= pend_nxt;
      retry   <= retry_nxt;
      err_ch  <= err_ch_nxt;
      for (int i = 0; i < NUM_CH; i++)
        dirty[i] <= (dac_fsadj[6*i +: 6] != hold[6*i +: 6]);
      if (state == S_VFY_WAIT) vfy_ok <= (spi.spi_data_out == data_q);
      case (state_nxt)
        S_RCML_START: begin
          reg_q  <= sel_rcml;
          data_q <= RCML_VALUE;
          rw_q   <= 1'b0;
        end
        S_RSET_START: begin
          reg_q                <= sel_rset;
          data_q               <= {2'b10, sel_code};
          rw_q                 <= 1'b0;
          hold[6*ch_nxt +: 6]  <= sel_code;
        end
        S_VFY_START: rw_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign spi.spi_reg     = reg_q;
  assign spi.spi_data_in = data_q;
  assign spi.spi_rw      = rw_q;
  assign spi.spi_send    = (state == S_RCML_START) || (state == S_RSET_START) || (state == S_VFY_START);

  assign dac_ready = (state == S_READY) && (dirty == '0);
  assign cfg_error = (state == S_ERROR);

endmodule
